// File: rtl/multi_tick_divider_pkg.sv
// Shared constants and helpers for the multi-channel tick/wave divider.
package multi_tick_pkg;
  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEFAULT_DIV = 25_000_000;

  // Divisor giving a square wave of hz (tick rate is 2*hz); 0 stops the channel.
  function automatic int unsigned div_for_hz(input int unsigned hz);
    return (hz == 0) ? 0 : CLK_HZ / (2 * hz);
  endfunction
endpackage

// File: rtl/multi_tick_divider_if.sv
// Divisor configuration handshake: valid/ready with channel index and divisor.
interface multi_tick_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/multi_tick_divider_tick_channel.sv
// One divider channel: counter, active/pending divisor, registered tick and wave.
module tick_channel #(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] DEF_DIV = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_div_i,
  output logic             tick_o,
  output logic             wave_o,
  output logic             pending_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
  logic             pend_q, pend_d, tick_q, tick_d, wave_q, wave_d;
  logic             wrap;

  // div_q != 0 guards the div-1 compare against underflow.
  assign wrap = (div_q != '0) && (cnt_q == div_q - 1'b1);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    wave_d = wave_q;
    if (sync_i) begin
      cnt_d  = '0;
      wave_d = 1'b0;
      if (pend_q) begin
        div_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else if (div_q == '0) begin
      cnt_d = '0;
      if (pend_q) begin
        div_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        wave_d = ~wave_q;
        if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Load is only granted while nothing is pending, so it never races an apply.
    if (load_i) begin
      pdiv_d = load_div_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV;
      pdiv_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      wave_q <= wave_d;
    end
  end

  assign tick_o    = tick_q;
  assign wave_o    = wave_q;
  assign pending_o = pend_q;
endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel runtime-programmable tick/square-wave divider.
module multi_tick_divider #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = multi_tick_pkg::DEFAULT_DIV
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  multi_tick_divider_if.slave cfg,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] wave_out
);
  import multi_tick_pkg::*;

  localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] pend;
  logic              ready;
  logic              accept;
  logic [CH_W-1:0]   ch_sel;

  assign ch_sel = cfg.cfg_ch;

  // Out-of-range channels always accept and the write is dropped.
  always_comb begin
    ready = 1'b1;
    if (int'(ch_sel) < NUM_CH) ready = ~pend[ch_sel];
  end

  assign cfg.cfg_ready = ~reset & ready;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i      (clk_in),
      .rst_i      (reset),
      .en_i       (enable),
      .sync_i     (sync),
      .load_i     (accept && (int'(ch_sel) == g)),
      .load_div_i (cfg.cfg_div),
      .tick_o     (tick_out[g]),
      .wave_o     (wave_out[g]),
      .pending_o  (pend[g])
    );
  end
endmodule

// File: tb/tb_multi_tick_divider.sv
// Directed bench for multi_tick_divider with DEFAULT_DIV = 4 on 4 channels.
module tb_multi_tick_divider;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic clk_in = 1'b0;
  logic reset, enable, sync;
  logic [NUM_CH-1:0] tick_out, wave_out;
  int errors = 0;
  int checks = 0;

  multi_tick_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  multi_tick_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .sync     (sync),
    .cfg      (cfg_if),
    .tick_out (tick_out),
    .wave_out (wave_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; sync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
    step(); step();
    reset = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; sync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
    step(); step();
    checks++; if (tick_out !== 4'h0) begin errors++; $display("FAIL rst_tick: got %h exp 0", tick_out); end
    checks++; if (wave_out !== 4'h0) begin errors++; $display("FAIL rst_wave: got %h exp 0", wave_out); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hi: got %b exp 0", cfg_if.cfg_ready); end
    reset = 1'b0; #1;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_lo: got %b exp 1", cfg_if.cfg_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] et, ew;
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      et = (k % 4 == 0) ? 4'hF : 4'h0;
      ew = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
      checks++; if (tick_out !== et) begin errors++; $display("FAIL basic_tick k=%0d: got %h exp %h", k, tick_out, et); end
      checks++; if (wave_out !== ew) begin errors++; $display("FAIL basic_wave k=%0d: got %h exp %h", k, wave_out, ew); end
    end
  endtask

  task automatic test_cfg_update();
    logic e, tg;
    apply_reset();
    step();
    cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd3; cfg_if.cfg_valid = 1'b1; #1;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL upd_ready_pre: got %b exp 1", cfg_if.cfg_ready); end
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL upd_ready_k2: got %b exp 0", cfg_if.cfg_ready); end
    step();
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL upd_ready_k3: got %b exp 0", cfg_if.cfg_ready); end
    step();
    checks++; if (tick_out[1] !== 1'b1) begin errors++; $display("FAIL upd_old_wrap: got %b exp 1", tick_out[1]); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL upd_ready_k4: got %b exp 1", cfg_if.cfg_ready); end
    tg = 1'b1;
    for (int k = 5; k <= 13; k++) begin
      step();
      e = ((k - 4) % 3 == 0);
      if (e) tg = ~tg;
      checks++; if (tick_out[1] !== e) begin errors++; $display("FAIL upd_tick1 k=%0d: got %b exp %b", k, tick_out[1], e); end
      checks++; if (wave_out[1] !== tg) begin errors++; $display("FAIL upd_wave1 k=%0d: got %b exp %b", k, wave_out[1], tg); end
      checks++; if (tick_out[0] !== (k % 4 == 0)) begin errors++; $display("FAIL upd_tick0 k=%0d: got %b exp %b", k, tick_out[0], (k % 4 == 0)); end
    end
  endtask

  task automatic test_stop_restart();
    apply_reset();
    cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 8'd0; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    step(); step(); step();
    checks++; if (tick_out[2] !== 1'b1) begin errors++; $display("FAIL stop_last_tick: got %b exp 1", tick_out[2]); end
    checks++; if (wave_out[2] !== 1'b1) begin errors++; $display("FAIL stop_last_wave: got %b exp 1", wave_out[2]); end
    for (int k = 5; k <= 7; k++) begin
      step();
      checks++; if (tick_out[2] !== 1'b0) begin errors++; $display("FAIL stop_tick k=%0d: got %b exp 0", k, tick_out[2]); end
      checks++; if (wave_out[2] !== 1'b1) begin errors++; $display("FAIL stop_wave k=%0d: got %b exp 1", k, wave_out[2]); end
    end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_ready: got %b exp 1", cfg_if.cfg_ready); end
    cfg_if.cfg_div = 8'd2; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL restart_pend: got %b exp 0", cfg_if.cfg_ready); end
    enable = 1'b0;
    step();
    enable = 1'b1;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL restart_applied: got %b exp 1", cfg_if.cfg_ready); end
    checks++; if (wave_out[2] !== 1'b1) begin errors++; $display("FAIL restart_wave_k9: got %b exp 1", wave_out[2]); end
    step();
    checks++; if (tick_out[2] !== 1'b0) begin errors++; $display("FAIL restart_tick_k10: got %b exp 0", tick_out[2]); end
    step();
    checks++; if (tick_out[2] !== 1'b1) begin errors++; $display("FAIL restart_tick_k11: got %b exp 1", tick_out[2]); end
    checks++; if (wave_out[2] !== 1'b0) begin errors++; $display("FAIL restart_wave_k11: got %b exp 0", wave_out[2]); end
  endtask

  task automatic test_enable_gap();
    apply_reset();
    step(); step();
    enable = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      step();
      checks++; if (tick_out !== 4'h0) begin errors++; $display("FAIL gap_tick k=%0d: got %h exp 0", k, tick_out); end
      checks++; if (wave_out !== 4'h0) begin errors++; $display("FAIL gap_wave k=%0d: got %h exp 0", k, wave_out); end
    end
    enable = 1'b1;
    step();
    checks++; if (tick_out !== 4'h0) begin errors++; $display("FAIL gap_tick_k8: got %h exp 0", tick_out); end
    step();
    checks++; if (tick_out !== 4'hF) begin errors++; $display("FAIL gap_tick_k9: got %h exp f", tick_out); end
    checks++; if (wave_out !== 4'hF) begin errors++; $display("FAIL gap_wave_k9: got %h exp f", wave_out); end
    enable = 1'b0;
    step();
    checks++; if (tick_out !== 4'h0) begin errors++; $display("FAIL gap_drop_tick: got %h exp 0", tick_out); end
    checks++; if (wave_out !== 4'hF) begin errors++; $display("FAIL gap_hold_wave: got %h exp f", wave_out); end
    enable = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      step();
      checks++; if (tick_out !== 4'h0) begin errors++; $display("FAIL gap_resume k=%0d: got %h exp 0", k, tick_out); end
    end
    step();
    checks++; if (tick_out !== 4'hF) begin errors++; $display("FAIL gap_tick_k14: got %h exp f", tick_out); end
    checks++; if (wave_out !== 4'h0) begin errors++; $display("FAIL gap_wave_k14: got %h exp 0", wave_out); end
  endtask

  task automatic test_sync();
    logic e;
    apply_reset();
    for (int k = 1; k <= 4; k++) step();
    cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd4; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 8'd6;
    step();
    cfg_if.cfg_valid = 1'b0; sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (wave_out !== 4'h0) begin errors++; $display("FAIL sync_wave: got %h exp 0", wave_out); end
    checks++; if (tick_out !== 4'h0) begin errors++; $display("FAIL sync_tick: got %h exp 0", tick_out); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL sync_applied: got %b exp 1", cfg_if.cfg_ready); end
    for (int k = 8; k <= 13; k++) begin
      step();
      checks++; if (tick_out[0] !== (k == 11)) begin errors++; $display("FAIL sync_tick0 k=%0d: got %b exp %b", k, tick_out[0], (k == 11)); end
      checks++; if (tick_out[3] !== (k == 13)) begin errors++; $display("FAIL sync_tick3 k=%0d: got %b exp %b", k, tick_out[3], (k == 13)); end
    end
    sync = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd2; cfg_if.cfg_valid = 1'b1;
    step();
    sync = 1'b0; cfg_if.cfg_valid = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL sync_cfg_pend: got %b exp 0", cfg_if.cfg_ready); end
    checks++; if (wave_out !== 4'h0) begin errors++; $display("FAIL sync2_wave: got %h exp 0", wave_out); end
    for (int k = 15; k <= 20; k++) begin
      step();
      e = (k == 18) || (k == 20);
      checks++; if (tick_out[1] !== e) begin errors++; $display("FAIL sync_cfg_tick1 k=%0d: got %b exp %b", k, tick_out[1], e); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 1; k <= 5; k++) step();
    cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd7; cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++; if (tick_out !== 4'h0) begin errors++; $display("FAIL mid_tick: got %h exp 0", tick_out); end
    checks++; if (wave_out !== 4'h0) begin errors++; $display("FAIL mid_wave: got %h exp 0", wave_out); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_hi: got %b exp 0", cfg_if.cfg_ready); end
    reset = 1'b0; #1;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_pend_clr: got %b exp 1", cfg_if.cfg_ready); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (tick_out[1] !== (k % 4 == 0)) begin errors++; $display("FAIL mid_div k=%0d: got %b exp %b", k, tick_out[1], (k % 4 == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_update();
    test_stop_restart();
    test_enable_gap();
    test_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
